// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM port arbiter.
//   state_e     : arbiter FSM states (IDLE, RMW_WR, RESP)
//   byte_merge  : one-byte select used to build the read-modify-write word
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_WR = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Returns the new byte when its enable is set, otherwise the old RAM byte.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    logic [7:0] res;
    res = be ? new_b : old_b;
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with optional round-robin.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   req[1:0]     : request lines (already qualified by the caller)
//   en           : grant window open; no grant is issued when low
//   rr_en        : 1 = round-robin on ties, 0 = requester 0 always wins
//   gnt[1:0]     : one-hot grant (or zero), combinational
// last_grant resets to 1 so requester 0 wins the first tie, and advances on
// every cycle a grant is issued.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) begin
        // Tie: round-robin picks the requester that was not granted last.
        if (rr_en && !last_grant) gnt = 2'b10;
        else                      gnt = 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one port of a write-first dual-port RAM between two requesters
// (0 = instruction fetch, 1 = load/store). Partial writes are done as
// read-modify-write because the RAM has no byte enables.
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_reqN_valid/o_reqN_ready : request handshake, N = 0,1
//   i_reqN_addr/we/be/wdata : request payload
//   o_reqN_ack/o_reqN_rdata : one-cycle completion pulse and its data
//   o_ram_addr/data/we      : RAM port drive (combinational)
//   i_ram_data              : RAM read data, 1-cycle latency, write-first
//   o_dbg_state             : current FSM state (state_e encoding)
//
// Handshake: a request transfers in the cycle where valid && ready are both
// high; the requester holds valid and payload stable until then. At most one
// ready is high per cycle and only while in IDLE or RESP and not in reset.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32,
  parameter int RR_EN      = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [AW-1:0]         i_req0_addr,
  input  logic                  i_req0_we,
  input  logic [BW-1:0]         i_req0_be,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ack,
  output logic [DATA_WIDTH-1:0] o_req0_rdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [AW-1:0]         i_req1_addr,
  input  logic                  i_req1_we,
  input  logic [BW-1:0]         i_req1_be,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ack,
  output logic [DATA_WIDTH-1:0] o_req1_rdata,
  output logic [AW-1:0]         o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic [1:0]            o_dbg_state
);

  state_e                state;
  logic                  owner_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0]         be_q;

  logic                  window;
  logic [1:0]            gnt;
  logic                  accept;
  logic                  sel;
  logic [AW-1:0]         a_addr;
  logic                  a_we;
  logic [BW-1:0]         a_be;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_full;
  logic [DATA_WIDTH-1:0] merged;

  // Reset is folded in combinationally so nothing is granted or written
  // while i_rst is high, even mid-cycle.
  assign window = ((state == IDLE) || (state == RESP)) && !i_rst;

  rr_arbiter2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req   ({i_req1_valid, i_req0_valid}),
    .en    (window),
    .rr_en (RR_EN != 0),
    .gnt   (gnt)
  );

  assign accept       = |gnt;
  assign sel          = gnt[1];
  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];

  assign a_addr  = sel ? i_req1_addr  : i_req0_addr;
  assign a_we    = sel ? i_req1_we    : i_req0_we;
  assign a_be    = sel ? i_req1_be    : i_req0_be;
  assign a_wdata = sel ? i_req1_wdata : i_req0_wdata;
  assign a_full  = &a_be;

  always_comb begin
    merged = '0;
    for (int k = 0; k < BW; k++) begin
      merged[8*k +: 8] = byte_merge(i_ram_data[8*k +: 8], wdata_q[8*k +: 8], be_q[k]);
    end
  end

  // RAM drive: RMW write-back, or the newly accepted request, else zeros.
  always_comb begin
    o_ram_addr = '0;
    o_ram_data = '0;
    o_ram_we   = 1'b0;
    if (!i_rst) begin
      if (state == RMW_WR) begin
        o_ram_addr = addr_q;
        o_ram_data = merged;
        o_ram_we   = 1'b1;
      end else if (accept) begin
        o_ram_addr = a_addr;
        if (a_we && a_full) begin
          o_ram_data = a_wdata;
          o_ram_we   = 1'b1;
        end
      end
    end
  end

  // Completion: the RAM output in RESP is the read word, or on writes the
  // word just written (write-first).
  always_comb begin
    o_req0_ack   = 1'b0;
    o_req1_ack   = 1'b0;
    o_req0_rdata = '0;
    o_req1_rdata = '0;
    if (!i_rst && state == RESP) begin
      if (owner_q) begin
        o_req1_ack   = 1'b1;
        o_req1_rdata = i_ram_data;
      end else begin
        o_req0_ack   = 1'b1;
        o_req0_rdata = i_ram_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            owner_q <= sel;
            if (a_we && !a_full) begin
              // be == 0 also lands here: the old word is rewritten unchanged.
              state   <= RMW_WR;
              addr_q  <= a_addr;
              wdata_q <= a_wdata;
              be_q    <= a_be;
            end else begin
              state <= RESP;
            end
          end else begin
            state <= IDLE;
          end
        end
        RMW_WR:  state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: a round-robin instance (dut_a) and a
// fixed-priority instance (dut_b) share stimulus, each with its own
// write-first RAM model.
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          v0, v1;
  logic [AW-1:0] addr0, addr1;
  logic          we0, we1;
  logic [BW-1:0] be0, be1;
  logic [DW-1:0] wd0, wd1;

  // ---------------- dut_a (RR_EN=1) ----------------
  logic          a_rdy0, a_rdy1, a_ack0, a_ack1, a_rwe;
  logic [DW-1:0] a_rd0, a_rd1, a_rdata_ram, a_wdata_ram;
  logic [AW-1:0] a_raddr;
  logic [1:0]    a_state;
  logic [DW-1:0] mem_a [0:255];

  ram_port_arbiter #(.DEPTH(256), .DATA_WIDTH(DW), .RR_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(a_rdy0), .i_req0_addr(addr0), .i_req0_we(we0),
    .i_req0_be(be0), .i_req0_wdata(wd0), .o_req0_ack(a_ack0), .o_req0_rdata(a_rd0),
    .i_req1_valid(v1), .o_req1_ready(a_rdy1), .i_req1_addr(addr1), .i_req1_we(we1),
    .i_req1_be(be1), .i_req1_wdata(wd1), .o_req1_ack(a_ack1), .o_req1_rdata(a_rd1),
    .o_ram_addr(a_raddr), .o_ram_data(a_wdata_ram), .o_ram_we(a_rwe),
    .i_ram_data(a_rdata_ram), .o_dbg_state(a_state)
  );

  always @(posedge clk) begin
    if (a_rwe) begin
      mem_a[a_raddr] <= a_wdata_ram;
      a_rdata_ram    <= a_wdata_ram;
    end else begin
      a_rdata_ram <= mem_a[a_raddr];
    end
  end

  // ---------------- dut_b (RR_EN=0) ----------------
  logic          b_rdy0, b_rdy1, b_ack0, b_ack1, b_rwe;
  logic [DW-1:0] b_rd0, b_rd1, b_rdata_ram, b_wdata_ram;
  logic [AW-1:0] b_raddr;
  logic [1:0]    b_state;
  logic [DW-1:0] mem_b [0:255];

  ram_port_arbiter #(.DEPTH(256), .DATA_WIDTH(DW), .RR_EN(0)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(b_rdy0), .i_req0_addr(addr0), .i_req0_we(we0),
    .i_req0_be(be0), .i_req0_wdata(wd0), .o_req0_ack(b_ack0), .o_req0_rdata(b_rd0),
    .i_req1_valid(v1), .o_req1_ready(b_rdy1), .i_req1_addr(addr1), .i_req1_we(we1),
    .i_req1_be(be1), .i_req1_wdata(wd1), .o_req1_ack(b_ack1), .o_req1_rdata(b_rd1),
    .o_ram_addr(b_raddr), .o_ram_data(b_wdata_ram), .o_ram_we(b_rwe),
    .i_ram_data(b_rdata_ram), .o_dbg_state(b_state)
  );

  always @(posedge clk) begin
    if (b_rwe) begin
      mem_b[b_raddr] <= b_wdata_ram;
      b_rdata_ram    <= b_wdata_ram;
    end else begin
      b_rdata_ram <= mem_b[b_raddr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    v0 = 1'b0; v1 = 1'b0;
    addr0 = '0; addr1 = '0; we0 = 1'b0; we1 = 1'b0;
    be0 = '0; be1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks dut_a's per-cycle outputs at the falling edge.
  task automatic check_a(input string tag, input logic [1:0] e_rdy, input logic e_we,
                         input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
                         input logic [1:0] e_ack, input logic [DW-1:0] e_rdata);
    @(negedge clk);
    check({tag, ".ready"},    32'({a_rdy1, a_rdy0}), 32'(e_rdy));
    check({tag, ".ram_we"},   32'(a_rwe), 32'(e_we));
    check({tag, ".ram_addr"}, 32'(a_raddr), 32'(e_addr));
    check({tag, ".ram_data"}, a_wdata_ram, e_data);
    check({tag, ".ack"},      32'({a_ack1, a_ack0}), 32'(e_ack));
    check({tag, ".rdata0"},   a_rd0, e_ack[0] ? e_rdata : 32'h0);
    check({tag, ".rdata1"},   a_rd1, e_ack[1] ? e_rdata : 32'h0);
  endtask

  task automatic do_reset();
    v0 = 1'b1; v1 = 1'b1; we0 = 1'b1; be0 = 4'hF; wd0 = 32'hFFFF_FFFF;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst.ready",  32'({a_rdy1, a_rdy0, b_rdy1, b_rdy0}), 32'h0);
      check("rst.ram_we", 32'({a_rwe, b_rwe}), 32'h0);
      check("rst.ack",    32'({a_ack1, a_ack0, b_ack1, b_ack0}), 32'h0);
      check("rst.state",  32'(a_state), 32'h0);
      next_cycle();
    end
    drive_idle();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v0, v1;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [1:0]    e_rdy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [1:0]    e_ack;
    logic [DW-1:0] e_rdata;
  } vec_t;

  function automatic vec_t mkv(logic iv0, logic iv1, logic [AW-1:0] ia, logic iw,
                               logic [BW-1:0] ib, logic [DW-1:0] id, logic [1:0] er,
                               logic ew, logic [AW-1:0] ea, logic [DW-1:0] ed,
                               logic [1:0] ek, logic [DW-1:0] erd);
    vec_t v;
    v.v0 = iv0; v.v1 = iv1; v.addr = ia; v.we = iw; v.be = ib; v.wdata = id;
    v.e_rdy = er; v.e_we = ew; v.e_addr = ea; v.e_data = ed; v.e_ack = ek; v.e_rdata = erd;
    return v;
  endfunction

  vec_t vecs [$];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[8'h10] = 32'hDEAD_BEEF; mem_b[8'h10] = 32'hDEAD_BEEF;
    mem_a[8'h30] = 32'hAABB_CCDD; mem_b[8'h30] = 32'hAABB_CCDD;
    mem_a[8'h50] = 32'h1234_0000; mem_b[8'h50] = 32'h1234_0000;
    drive_idle();

    // One record per cycle: inputs (payload shared by both requesters),
    // then expected ready, ram_we/addr/data, ack and ack data.
    // single read of 0x10
    vecs.push_back(mkv(1, 0, 8'h10, 0, 4'hF, 32'h0,          2'b01, 0, 8'h10, 32'h0,          2'b00, 32'h0));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b01, 32'hDEAD_BEEF));
    // full write from requester 1, then read back
    vecs.push_back(mkv(0, 1, 8'h20, 1, 4'hF, 32'h1234_5678,  2'b10, 1, 8'h20, 32'h1234_5678,  2'b00, 32'h0));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b10, 32'h1234_5678));
    vecs.push_back(mkv(1, 0, 8'h20, 0, 4'hF, 32'h0,          2'b01, 0, 8'h20, 32'h0,          2'b00, 32'h0));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b01, 32'h1234_5678));
    // partial write; requester 1 waits through RMW_WR and is taken in RESP
    vecs.push_back(mkv(1, 0, 8'h30, 1, 4'h5, 32'h1122_3344,  2'b01, 0, 8'h30, 32'h0,          2'b00, 32'h0));
    vecs.push_back(mkv(0, 1, 8'h10, 0, 4'hF, 32'h0,          2'b00, 1, 8'h30, 32'hAA22_CC44,  2'b00, 32'h0));
    vecs.push_back(mkv(0, 1, 8'h10, 0, 4'hF, 32'h0,          2'b10, 0, 8'h10, 32'h0,          2'b01, 32'hAA22_CC44));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b10, 32'hDEAD_BEEF));
    // read accepted in RESP of a write to the same address
    vecs.push_back(mkv(0, 1, 8'h40, 1, 4'hF, 32'h5A5A_5A5A,  2'b10, 1, 8'h40, 32'h5A5A_5A5A,  2'b00, 32'h0));
    vecs.push_back(mkv(1, 0, 8'h40, 0, 4'hF, 32'h0,          2'b01, 0, 8'h40, 32'h0,          2'b10, 32'h5A5A_5A5A));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b01, 32'h5A5A_5A5A));
    // be == 0 write goes through RMW and leaves the word unchanged
    vecs.push_back(mkv(0, 1, 8'h40, 1, 4'h0, 32'hFFFF_FFFF,  2'b10, 0, 8'h40, 32'h0,          2'b00, 32'h0));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 1, 8'h40, 32'h5A5A_5A5A,  2'b00, 32'h0));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b10, 32'h5A5A_5A5A));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 4'h0, 32'h0,          2'b00, 0, 8'h00, 32'h0,          2'b00, 32'h0));

    // reset state
    next_cycle();
    do_reset();

    foreach (vecs[i]) begin
      v0 = vecs[i].v0; v1 = vecs[i].v1;
      addr0 = vecs[i].addr; addr1 = vecs[i].addr;
      we0 = vecs[i].we; we1 = vecs[i].we;
      be0 = vecs[i].be; be1 = vecs[i].be;
      wd0 = vecs[i].wdata; wd1 = vecs[i].wdata;
      check_a($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_addr,
              vecs[i].e_data, vecs[i].e_ack, vecs[i].e_rdata);
      next_cycle();
    end
    drive_idle();

    // Both requesters read continuously. After reset requester 0 wins the
    // first tie; RR alternates, fixed priority never serves requester 1.
    do_reset();
    v0 = 1'b1; addr0 = 8'h10;
    v1 = 1'b1; addr1 = 8'h20;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d.ready", k), 32'({a_rdy1, a_rdy0}), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        exp_q.push_back(((k - 1) % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
        check($sformatf("rr%0d.ack", k), 32'({a_ack1, a_ack0}), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
        check($sformatf("rr%0d.rdata", k), a_rd0 | a_rd1, exp_q.pop_front());
        check($sformatf("fp%0d.ack", k), 32'({b_ack1, b_ack0}), 32'h1);
        check($sformatf("fp%0d.rdata0", k), b_rd0, 32'hDEAD_BEEF);
      end
      check($sformatf("fp%0d.ready", k), 32'({b_rdy1, b_rdy0}), 32'h1);
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    check("rr_tail.ack",   32'({a_ack1, a_ack0}), 32'h2);
    check("rr_tail.rdata", a_rd1, 32'h1234_5678);
    check("fp_tail.ack",   32'({b_ack1, b_ack0}), 32'h1);
    next_cycle();

    // Reset during RMW_WR drops the write; the reissued write completes.
    v0 = 1'b1; addr0 = 8'h50; we0 = 1'b1; be0 = 4'b0011; wd0 = 32'h0000_BEEF;
    @(negedge clk);
    check("rmwrst.accept", 32'(a_rdy0), 32'h1);
    next_cycle();
    drive_idle();
    check("rmwrst.in_rmw", 32'(a_state), 32'h1);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rmwrst.ram_we", 32'(a_rwe), 32'h0);
    check("rmwrst.ack",    32'({a_ack1, a_ack0}), 32'h0);
    check("rmwrst.state",  32'(a_state), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rmwrst.no_ack", 32'({a_ack1, a_ack0}), 32'h0);
    check("rmwrst.mem",    mem_a[8'h50], 32'h1234_0000);
    next_cycle();
    v0 = 1'b1; addr0 = 8'h50; we0 = 1'b1; be0 = 4'b0011; wd0 = 32'h0000_BEEF;
    check_a("reissue0", 2'b01, 1'b0, 8'h50, 32'h0, 2'b00, 32'h0);
    next_cycle();
    drive_idle();
    check_a("reissue1", 2'b00, 1'b1, 8'h50, 32'h1234_BEEF, 2'b00, 32'h0);
    next_cycle();
    check_a("reissue2", 2'b00, 1'b0, 8'h00, 32'h0, 2'b01, 32'h1234_BEEF);
    next_cycle();
    @(negedge clk);
    check("reissue.mem", mem_a[8'h50], 32'h1234_BEEF);
    check("idle.state",  32'(a_state), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
